score_display_ctrl: RTL and testbench
=====================================

SCORE_DISPLAY_CTRL -- requirements
Module: score_display_ctrl

Interface
REQ-001 SHALL have parameter DIGIT_W, default 11, digit sprite width in pixels.
REQ-002 SHALL have parameter DIGIT_H, default 16, digit sprite height in pixels.
REQ-003 SHALL have parameter LEFT_X, default 280, left-score box first column.
REQ-004 SHALL have parameter RIGHT_X, default 349, right-score box first column.
REQ-005 SHALL have parameter TOP_Y, default 20, first row of both boxes.
REQ-006 SHALL have parameter WIN_SCORE, default 9, score that ends the game (1..9).
REQ-007 SHALL have parameter BLINK_FRAMES, default 30, frames per blink half-period.
REQ-008 SHALL have port clk, input, 1 bit, single system clock; all logic rising-edge.
REQ-009 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-010 SHALL have port row, input, 10 bits, current VGA pixel row.
REQ-011 SHALL have port col, input, 10 bits, current VGA pixel column.
REQ-012 SHALL have port frame_start, input, 1 bit, one-cycle pulse per frame.
REQ-013 SHALL have ports point_left and point_right, input, 1 bit each, one-cycle scoring pulses.
REQ-014 SHALL have port game_restart, input, 1 bit, one-cycle restart pulse.
REQ-015 SHALL have port rom_digit, output, 4 bits, digit value selecting the shared sprite ROM.
REQ-016 SHALL have ports rom_row and rom_col, output, 10 bits each, sprite-local coordinates to the ROM.
REQ-017 SHALL have port rom_rgb, input, 3 bits, combinational ROM pixel for rom_digit/rom_row/rom_col.
REQ-018 SHALL have port rgb, output, 3 bits, registered score-overlay pixel.
REQ-019 SHALL have ports score_left and score_right, output, 4 bits each, current scores.
REQ-020 SHALL have ports game_over, output, 1 bit, and winner, output, 1 bit (0 = left, 1 = right).

Function
REQ-021 SHALL implement FSM states PLAY and OVER; reset state PLAY.
REQ-022 In PLAY, point_left SHALL increment score_left by 1; point_right SHALL increment score_right by 1; simultaneous pulses SHALL increment both.
REQ-023 When any score reaches WIN_SCORE, SHALL enter OVER the next cycle with game_over=1; the winner is the side at WIN_SCORE, and left wins if both reach it in the same cycle.
REQ-024 In OVER, point pulses SHALL be ignored and scores SHALL hold; no score SHALL exceed WIN_SCORE.
REQ-025 game_restart SHALL, in any state, clear both scores, game_over, winner and the blink logic, and enter PLAY; it SHALL take priority over same-cycle point pulses.
REQ-026 Pipeline stage 1 SHALL register: hit_left = (LEFT_X <= col < LEFT_X+DIGIT_W) and (TOP_Y <= row < TOP_Y+DIGIT_H); hit_right likewise with RIGHT_X; local row = row-TOP_Y; local col = col-box X.
REQ-027 rom_digit/rom_row/rom_col SHALL be driven from stage-1 registers: the left score and its local coordinates on hit_left, the right score on hit_right, otherwise digit 0 at coordinates 0,0.
REQ-028 Stage 2 SHALL register rgb = rom_rgb when (hit_left or hit_right) and the digit is visible, otherwise 3'b000; total latency from row/col to rgb is 2 cycles.
REQ-029 Blink: a frame counter SHALL count frame_start pulses in OVER only, wrap at BLINK_FRAMES-1, and toggle a blink bit on wrap; it SHALL be cleared on entry to OVER.
REQ-030 In OVER, the winner's digit SHALL be visible only while blink=0; the loser's digit is always visible; in PLAY both are always visible.
REQ-031 Scores SHALL change only at clock edges; a pixel already in the pipeline SHALL use the score held in its stage-1 register (no mid-pixel tearing).

Reset
REQ-032 While rst_n=0, regardless of clk: score_left=0, score_right=0, game_over=0, winner=0, rgb=000, all pipeline registers 0, blink and frame counter 0, state PLAY.
REQ-033 Reset deassertion SHALL take effect at the first rising clk edge after rst_n=1; reset asserted mid-game SHALL discard all state.

Verification
REQ-034 Reset: rst_n low mid-frame -> all outputs 0 immediately, without a clock edge.
REQ-035 Scoring: 3 point_left pulses, 1 point_right -> score_left=3, score_right=1, game_over=0.
REQ-036 Render: score_left=3, row=20, col=280 -> rom_digit=3, rom_row=0, rom_col=0 one cycle later, rgb=rom_rgb two cycles later; col=291 -> rgb=000.
REQ-037 Win tie: both scores 8, simultaneous point pulses -> both 9, game_over=1, winner=0; further pulses ignored.
REQ-038 Blink: in OVER with BLINK_FRAMES=2, after 2 frame_start pulses the winner box -> 000 while the loser box still renders; after 2 more it renders again.
REQ-039 Restart: game_restart together with point_right in OVER -> scores 0, game_over=0, state PLAY, point discarded.

Source files
------------

// File: rtl/score_display_ctrl.sv
// Pong score overlay: tracks both scores, detects the win, blinks the winner's digit,
// and renders the score boxes through a shared sprite ROM with a 2-cycle row/col -> rgb pipeline.
module score_display_ctrl #(
    parameter int DIGIT_W      = 11,
    parameter int DIGIT_H      = 16,
    parameter int LEFT_X       = 280,
    parameter int RIGHT_X      = 349,
    parameter int TOP_Y        = 20,
    parameter int WIN_SCORE    = 9,
    parameter int BLINK_FRAMES = 30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] row,
    input  logic [9:0] col,
    input  logic       frame_start,
    input  logic       point_left,
    input  logic       point_right,
    input  logic       game_restart,
    output logic [3:0] rom_digit,
    output logic [9:0] rom_row,
    output logic [9:0] rom_col,
    input  logic [2:0] rom_rgb,
    output logic [2:0] rgb,
    output logic [3:0] score_left,
    output logic [3:0] score_right,
    output logic       game_over,
    output logic       winner
);

    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);
    localparam logic [3:0]  WIN  = 4'(WIN_SCORE);
    localparam logic [10:0] LX0  = 11'(LEFT_X);
    localparam logic [10:0] LX1  = 11'(LEFT_X + DIGIT_W);
    localparam logic [10:0] RX0  = 11'(RIGHT_X);
    localparam logic [10:0] RX1  = 11'(RIGHT_X + DIGIT_W);
    localparam logic [10:0] TY0  = 11'(TOP_Y);
    localparam logic [10:0] TY1  = 11'(TOP_Y + DIGIT_H);
    localparam logic [9:0]  LXC  = 10'(LEFT_X);
    localparam logic [9:0]  RXC  = 10'(RIGHT_X);
    localparam logic [9:0]  TYC  = 10'(TOP_Y);

    typedef enum logic {PLAY, OVER} state_t;

    state_t        state;
    logic [FW-1:0] frame_cnt;
    logic          blink;
    logic [3:0]    next_left;
    logic [3:0]    next_right;

    always_comb begin
        next_left  = score_left + {3'b000, point_left};
        next_right = score_right + {3'b000, point_right};
    end

    // Game FSM; the move to OVER happens on the same edge that lands the winning point,
    // so no further increment can ever push a score past WIN_SCORE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= PLAY;
            score_left  <= 4'd0;
            score_right <= 4'd0;
            game_over   <= 1'b0;
            winner      <= 1'b0;
            frame_cnt   <= '0;
            blink       <= 1'b0;
        end else if (game_restart) begin
            state       <= PLAY;
            score_left  <= 4'd0;
            score_right <= 4'd0;
            game_over   <= 1'b0;
            winner      <= 1'b0;
            frame_cnt   <= '0;
            blink       <= 1'b0;
        end else begin
            case (state)
                PLAY: begin
                    score_left  <= next_left;
                    score_right <= next_right;
                    if (next_left == WIN || next_right == WIN) begin
                        state     <= OVER;
                        game_over <= 1'b1;
                        winner    <= (next_left != WIN);
                        frame_cnt <= '0;
                        blink     <= 1'b0;
                    end
                end
                OVER: begin
                    if (frame_start) begin
                        if (frame_cnt == FRAME_LAST) begin
                            frame_cnt <= '0;
                            blink     <= ~blink;
                        end else begin
                            frame_cnt <= frame_cnt + 1'b1;
                        end
                    end
                end
                default: state <= PLAY;
            endcase
        end
    end

    logic row_in, hit_l, hit_r, vis_l, vis_r;
    logic s1_hit_l, s1_hit_r, s1_vis;

    always_comb begin
        row_in = ({1'b0, row} >= TY0) && ({1'b0, row} < TY1);
        hit_l  = row_in && ({1'b0, col} >= LX0) && ({1'b0, col} < LX1);
        hit_r  = row_in && ({1'b0, col} >= RX0) && ({1'b0, col} < RX1);
        vis_l  = !((state == OVER) && !winner && blink);
        vis_r  = !((state == OVER) && winner && blink);
    end

    // Stage 1 snapshots the digit and its visibility so a pixel in flight never tears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_hit_l  <= 1'b0;
            s1_hit_r  <= 1'b0;
            s1_vis    <= 1'b0;
            rom_digit <= 4'd0;
            rom_row   <= 10'd0;
            rom_col   <= 10'd0;
            rgb       <= 3'b000;
        end else begin
            s1_hit_l <= hit_l;
            s1_hit_r <= hit_r;
            if (hit_l) begin
                rom_digit <= score_left;
                rom_row   <= row - TYC;
                rom_col   <= col - LXC;
                s1_vis    <= vis_l;
            end else if (hit_r) begin
                rom_digit <= score_right;
                rom_row   <= row - TYC;
                rom_col   <= col - RXC;
                s1_vis    <= vis_r;
            end else begin
                rom_digit <= 4'd0;
                rom_row   <= 10'd0;
                rom_col   <= 10'd0;
                s1_vis    <= 1'b0;
            end
            rgb <= ((s1_hit_l || s1_hit_r) && s1_vis) ? rom_rgb : 3'b000;
        end
    end

endmodule

// File: tb/tb_score_display_ctrl.sv
// Self-checking bench for score_display_ctrl: vector table, hand-written corner sequences,
// and a randomized run against a rule-level game/pixel model.
module tb_score_display_ctrl;

    localparam int W = 11, H = 16, LX = 280, RX = 349, TY = 20, WS = 9, BF = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] row = '0, col = '0;
    logic       frame_start = 1'b0, point_left = 1'b0, point_right = 1'b0, game_restart = 1'b0;
    logic [3:0] rom_digit, score_left, score_right;
    logic [9:0] rom_row, rom_col;
    logic [2:0] rom_rgb, rgb;
    logic       game_over, winner;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    function automatic logic [2:0] rom_fn(int d, int r, int c);
        return 3'((d + r + c) % 7 + 1);
    endfunction

    assign rom_rgb = rom_fn(int'(rom_digit), int'(rom_row), int'(rom_col));

    score_display_ctrl #(
        .DIGIT_W(W), .DIGIT_H(H), .LEFT_X(LX), .RIGHT_X(RX), .TOP_Y(TY),
        .WIN_SCORE(WS), .BLINK_FRAMES(BF)
    ) dut (
        .clk(clk), .rst_n(rst_n), .row(row), .col(col), .frame_start(frame_start),
        .point_left(point_left), .point_right(point_right), .game_restart(game_restart),
        .rom_digit(rom_digit), .rom_row(rom_row), .rom_col(rom_col), .rom_rgb(rom_rgb),
        .rgb(rgb), .score_left(score_left), .score_right(score_right),
        .game_over(game_over), .winner(winner)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic pl, input logic pr, input logic rs, input logic fs);
        @(negedge clk);
        point_left = pl; point_right = pr; game_restart = rs; frame_start = fs;
        @(posedge clk); #1;
        point_left = 0; point_right = 0; game_restart = 0; frame_start = 0;
    endtask

    task automatic pix_check(input string name, input int r, input int c, input logic [2:0] exp);
        @(negedge clk);
        row = 10'(r); col = 10'(c);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check(name, 32'(rgb), 32'(exp));
    endtask

    // Rule-level reference model of the game.
    int m_l, m_r, m_frames;
    bit m_over, m_win;

    function automatic logic [2:0] pix(int r, int c);
        bit blink;
        blink = ((m_frames / BF) % 2) == 1;
        if (r >= TY && r < TY + H && c >= LX && c < LX + W)
            return (m_over && m_win == 0 && blink) ? 3'b000 : rom_fn(m_l, r - TY, c - LX);
        if (r >= TY && r < TY + H && c >= RX && c < RX + W)
            return (m_over && m_win == 1 && blink) ? 3'b000 : rom_fn(m_r, r - TY, c - RX);
        return 3'b000;
    endfunction

    typedef struct {
        int r; int c; int d; int lr; int lc; bit on;
    } vec_t;
    vec_t vt[11];

    initial begin
        logic [2:0] prev_exp;
        bit pl, pr, rs, fs;

        vt[0]  = '{20, 280, 3, 0, 0, 1};
        vt[1]  = '{20, 290, 3, 0, 10, 1};
        vt[2]  = '{20, 291, 0, 0, 0, 0};
        vt[3]  = '{35, 280, 3, 15, 0, 1};
        vt[4]  = '{36, 280, 0, 0, 0, 0};
        vt[5]  = '{19, 280, 0, 0, 0, 0};
        vt[6]  = '{20, 279, 0, 0, 0, 0};
        vt[7]  = '{20, 349, 1, 0, 0, 1};
        vt[8]  = '{35, 359, 1, 15, 10, 1};
        vt[9]  = '{25, 360, 0, 0, 0, 0};
        vt[10] = '{27, 285, 3, 7, 5, 1};

        // Reset state, before any clock edge.
        #2;
        check("reset score_left", 32'(score_left), 0);
        check("reset score_right", 32'(score_right), 0);
        check("reset game_over", 32'(game_over), 0);
        check("reset rgb", 32'(rgb), 0);
        @(negedge clk); rst_n = 1;

        // Scoring.
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        check("score_left=3", 32'(score_left), 3);
        check("score_right=1", 32'(score_right), 1);
        check("game_over after 4 points", 32'(game_over), 0);

        // Render table with left=3, right=1.
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            row = 10'(vt[i].r); col = 10'(vt[i].c);
            @(posedge clk); #1;
            check($sformatf("vec%0d rom_digit", i), 32'(rom_digit), 32'(vt[i].d));
            check($sformatf("vec%0d rom_row", i), 32'(rom_row), 32'(vt[i].lr));
            check($sformatf("vec%0d rom_col", i), 32'(rom_col), 32'(vt[i].lc));
            @(posedge clk); #1;
            check($sformatf("vec%0d rgb", i), 32'(rgb),
                  32'(vt[i].on ? rom_fn(vt[i].d, vt[i].lr, vt[i].lc) : 3'b000));
        end

        // Asynchronous reset mid-frame with a live pixel in the pipeline.
        @(negedge clk); row = 10'd20; col = 10'd280;
        @(posedge clk); @(posedge clk); #3;
        rst_n = 0;
        #1;
        check("async rst score_left", 32'(score_left), 0);
        check("async rst score_right", 32'(score_right), 0);
        check("async rst rgb", 32'(rgb), 0);
        check("async rst rom_digit", 32'(rom_digit), 0);
        check("async rst rom_col", 32'({winner, game_over, rom_row, rom_col}), 0);
        @(negedge clk); rst_n = 1;

        // Tie at WIN_SCORE: left wins, scores freeze.
        for (int i = 0; i < 8; i++) step(1, 1, 0, 0);
        check("tie pre score_left=8", 32'(score_left), 8);
        check("tie pre game_over", 32'(game_over), 0);
        step(1, 1, 0, 0);
        check("tie score_left", 32'(score_left), 9);
        check("tie score_right", 32'(score_right), 9);
        check("tie game_over", 32'(game_over), 1);
        check("tie winner", 32'(winner), 0);
        step(1, 1, 0, 0);
        step(0, 1, 0, 0);
        check("over hold left", 32'(score_left), 9);
        check("over hold right", 32'(score_right), 9);

        // Blink with BLINK_FRAMES=2.
        pix_check("blink0 winner on", 20, 280, rom_fn(9, 0, 0));
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        pix_check("blink1 winner off", 20, 280, 3'b000);
        pix_check("blink1 loser on", 25, 352, rom_fn(9, 5, 3));
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        pix_check("blink2 winner on", 20, 280, rom_fn(9, 0, 0));

        // Restart beats a same-cycle point.
        step(0, 1, 1, 0);
        check("restart score_left", 32'(score_left), 0);
        check("restart score_right", 32'(score_right), 0);
        check("restart game_over/winner", 32'({game_over, winner}), 0);
        step(0, 1, 0, 0);
        check("play after restart", 32'(score_right), 1);
        step(0, 0, 1, 0);

        // Randomized play checked against the model.
        m_l = 0; m_r = 0; m_frames = 0; m_over = 0; m_win = 0;
        prev_exp = 3'b000;
        for (int k = 0; k < 3000; k++) begin
            logic [2:0] e;
            @(negedge clk);
            pl = ($urandom_range(0, 3) == 0);
            pr = ($urandom_range(0, 3) == 0);
            rs = ($urandom_range(0, 299) == 0);
            fs = ($urandom_range(0, 2) == 0);
            point_left = pl; point_right = pr; game_restart = rs; frame_start = fs;
            row = 10'($urandom_range(15, 40));
            col = 10'($urandom_range(275, 365));
            e = pix(int'(row), int'(col));
            @(posedge clk); #1;
            if (rs) begin
                m_l = 0; m_r = 0; m_over = 0; m_win = 0; m_frames = 0;
            end else if (!m_over) begin
                m_l += int'(pl); m_r += int'(pr);
                if (m_l == WS || m_r == WS) begin
                    m_over = 1; m_win = (m_l == WS) ? 0 : 1; m_frames = 0;
                end
            end else if (fs) begin
                m_frames++;
            end
            check("rand scores", 32'({score_left, score_right}), 32'((m_l << 4) | m_r));
            check("rand over/winner", 32'({game_over, winner}), 32'({m_over, m_win}));
            if (k > 0) check("rand rgb", 32'(rgb), 32'(prev_exp));
            prev_exp = e;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
